// File: rtl/axil_bram_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to BRAM bridge.
package axil_bram_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    BRESP = 3'd2,
    RD    = 3'd3,
    RWAIT = 3'd4,
    RRESP = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  // Kept for completeness; the bridge never reports an error.
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_bram_bridge_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the bridge (slave).
interface axil_bram_bridge_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [31:0]           s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axil_bram_bridge.sv
// AXI4-Lite slave to BRAM master bridge, one transaction in flight.
// Optional: define AXIL_BRAM_BRIDGE_RR_ARB_EN for round-robin read/write
// arbitration; otherwise writes win when both sides are eligible.
module axil_bram_bridge
  import axil_bram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  axil_bram_bridge_if.slave     s_axil,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [31:0]           bram_wrdata,
  input  logic [31:0]           bram_rddata
);

  // Word alignment mask: low two address bits are always driven to zero.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  // Extra RWAIT cycles beyond the first one.
  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  state_t     r_state;
  logic [1:0] r_lat_cnt;

  logic w_idle;
  logic w_wr_elig;
  logic w_rd_elig;
  logic w_wr_wins;
  logic w_grant_wr;
  logic w_grant_rd;

  // Readies stay low while reset is held so nothing is accepted during reset.
  assign w_idle    = (r_state == IDLE) && !rst;
  assign w_wr_elig = w_idle && s_axil.s_awvalid && s_axil.s_wvalid;
  assign w_rd_elig = w_idle && s_axil.s_arvalid;

`ifdef AXIL_BRAM_BRIDGE_RR_ARB_EN
  logic r_last_wr;  // 1 = last grant went to the write side

  // Remember which side was granted most recently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_wr <= 1'b0;
    end else if (w_grant_wr) begin
      r_last_wr <= 1'b1;
    end else if (w_grant_rd) begin
      r_last_wr <= 1'b0;
    end else begin
      r_last_wr <= r_last_wr;
    end
  end

  assign w_wr_wins = !r_last_wr;
`else
  assign w_wr_wins = 1'b1;
`endif

  assign w_grant_wr = w_wr_elig && (!w_rd_elig || w_wr_wins);
  assign w_grant_rd = w_rd_elig && !w_grant_wr;

  assign s_axil.s_awready = w_grant_wr;
  assign s_axil.s_wready  = w_grant_wr;
  assign s_axil.s_arready = w_grant_rd;

  // Main FSM: sequences the BRAM cycle and the registered AXI responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_lat_cnt       <= 2'd0;
      bram_addr       <= '0;
      bram_en         <= 1'b0;
      bram_we         <= 4'h0;
      bram_wrdata     <= 32'h0;
      s_axil.s_bvalid <= 1'b0;
      s_axil.s_bresp  <= RESP_OKAY;
      s_axil.s_rvalid <= 1'b0;
      s_axil.s_rresp  <= RESP_OKAY;
      s_axil.s_rdata  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_wr) begin
            bram_addr   <= s_axil.s_awaddr & ALIGN_MASK;
            bram_wrdata <= s_axil.s_wdata;
            bram_we     <= s_axil.s_wstrb;
            bram_en     <= 1'b1;
            r_state     <= WR;
          end else if (w_grant_rd) begin
            bram_addr <= s_axil.s_araddr & ALIGN_MASK;
            bram_we   <= 4'h0;
            bram_en   <= 1'b1;
            r_state   <= RD;
          end else begin
            r_state <= IDLE;
          end
        end
        WR: begin
          bram_en         <= 1'b0;
          bram_we         <= 4'h0;
          s_axil.s_bvalid <= 1'b1;
          s_axil.s_bresp  <= RESP_OKAY;
          r_state         <= BRESP;
        end
        BRESP: begin
          if (s_axil.s_bready) begin
            s_axil.s_bvalid <= 1'b0;
            r_state         <= IDLE;
          end else begin
            r_state <= BRESP;
          end
        end
        RD: begin
          bram_en   <= 1'b0;
          r_lat_cnt <= LAT_M1;
          r_state   <= RWAIT;
        end
        RWAIT: begin
          if (r_lat_cnt == 2'd0) begin
            s_axil.s_rdata  <= bram_rddata;
            s_axil.s_rvalid <= 1'b1;
            s_axil.s_rresp  <= RESP_OKAY;
            r_state         <= RRESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
            r_state   <= RWAIT;
          end
        end
        RRESP: begin
          if (s_axil.s_rready) begin
            s_axil.s_rvalid <= 1'b0;
            r_state         <= IDLE;
          end else begin
            r_state <= RRESP;
          end
        end
        default: begin
          bram_en         <= 1'b0;
          bram_we         <= 4'h0;
          s_axil.s_bvalid <= 1'b0;
          s_axil.s_rvalid <= 1'b0;
          r_state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_bram_bridge.sv
// Directed bench for axil_bram_bridge: vector table plus corner sequences.
module tb_axil_bram_bridge;

  localparam logic [31:0] GARB = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_bram_bridge_if #(.ADDR_WIDTH(16)) bus1 ();
  axil_bram_bridge_if #(.ADDR_WIDTH(16)) bus3 ();

  logic [15:0] bram_addr1, bram_addr3;
  logic        bram_en1, bram_en3;
  logic [3:0]  bram_we1, bram_we3;
  logic [31:0] bram_wrdata1, bram_wrdata3;
  logic [31:0] bram_rddata1, bram_rddata3;

  axil_bram_bridge #(.ADDR_WIDTH(16), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .s_axil(bus1.slave),
    .bram_addr(bram_addr1), .bram_en(bram_en1), .bram_we(bram_we1),
    .bram_wrdata(bram_wrdata1), .bram_rddata(bram_rddata1)
  );

  axil_bram_bridge #(.ADDR_WIDTH(16), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .s_axil(bus3.slave),
    .bram_addr(bram_addr3), .bram_en(bram_en3), .bram_we(bram_we3),
    .bram_wrdata(bram_wrdata3), .bram_rddata(bram_rddata3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;

  // Count BRAM cycles issued by the latency-1 bridge.
  always @(posedge clk) begin
    if (bram_en1) en_cnt <= en_cnt + 1;
  end

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] data;   // wdata for writes, bram_rddata for reads
    logic [3:0]  strb;
    int          hold;   // rready=0 cycles after rvalid rises
    logic [15:0] exp_addr;
    logic [3:0]  exp_we;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_write(input vec_t v);
    next();
    bus1.s_awaddr = v.addr; bus1.s_wdata = v.data; bus1.s_wstrb = v.strb;
    bus1.s_awvalid = 1'b1; bus1.s_wvalid = 1'b1; bus1.s_bready = 1'b1;
    mid();
    chk("wr_awready", {31'd0, bus1.s_awready}, 32'd1);
    chk("wr_wready", {31'd0, bus1.s_wready}, 32'd1);
    next();
    bus1.s_awvalid = 1'b0; bus1.s_wvalid = 1'b0;
    mid();
    chk("wr_bram_en", {31'd0, bram_en1}, 32'd1);
    chk("wr_bram_we", {28'd0, bram_we1}, {28'd0, v.exp_we});
    chk("wr_bram_addr", {16'd0, bram_addr1}, {16'd0, v.exp_addr});
    chk("wr_bram_wrdata", bram_wrdata1, v.data);
    chk("wr_bvalid_early", {31'd0, bus1.s_bvalid}, 32'd0);
    next();
    mid();
    chk("wr_bvalid", {31'd0, bus1.s_bvalid}, 32'd1);
    chk("wr_bresp", {30'd0, bus1.s_bresp}, 32'd0);
    chk("wr_en_off", {27'd0, bram_en1, bram_we1}, 32'd0);
    next();
    bus1.s_bready = 1'b0;
    mid();
    chk("wr_bvalid_done", {31'd0, bus1.s_bvalid}, 32'd0);
  endtask

  task automatic do_read(input vec_t v);
    next();
    bus1.s_araddr = v.addr; bus1.s_arvalid = 1'b1; bus1.s_rready = 1'b0;
    mid();
    chk("rd_arready", {31'd0, bus1.s_arready}, 32'd1);
    next();
    bus1.s_arvalid = 1'b0;
    mid();
    chk("rd_bram_en", {31'd0, bram_en1}, 32'd1);
    chk("rd_bram_we", {28'd0, bram_we1}, 32'd0);
    chk("rd_bram_addr", {16'd0, bram_addr1}, {16'd0, v.exp_addr});
    next();
    bram_rddata1 = v.data;
    mid();
    chk("rd_rvalid_early", {31'd0, bus1.s_rvalid}, 32'd0);
    next();
    bram_rddata1 = GARB;
    mid();
    chk("rd_rvalid", {31'd0, bus1.s_rvalid}, 32'd1);
    chk("rd_rdata", bus1.s_rdata, v.data);
    chk("rd_rresp", {30'd0, bus1.s_rresp}, 32'd0);
    for (int i = 0; i < v.hold; i++) begin
      next();
      mid();
      chk("rd_hold_rvalid", {31'd0, bus1.s_rvalid}, 32'd1);
      chk("rd_hold_rdata", bus1.s_rdata, v.data);
    end
    next();
    bus1.s_rready = 1'b1;
    mid();
    next();
    bus1.s_rready = 1'b0;
    mid();
    chk("rd_rvalid_done", {31'd0, bus1.s_rvalid}, 32'd0);
  endtask

  initial begin
    int base;
    int g;
    int exp_g;
    int rv_seen;

    bus1.s_awaddr = '0; bus1.s_awvalid = 1'b0; bus1.s_wdata = '0; bus1.s_wstrb = '0;
    bus1.s_wvalid = 1'b0; bus1.s_bready = 1'b0; bus1.s_araddr = '0;
    bus1.s_arvalid = 1'b0; bus1.s_rready = 1'b0;
    bus3.s_awaddr = '0; bus3.s_awvalid = 1'b0; bus3.s_wdata = '0; bus3.s_wstrb = '0;
    bus3.s_wvalid = 1'b0; bus3.s_bready = 1'b0; bus3.s_araddr = '0;
    bus3.s_arvalid = 1'b0; bus3.s_rready = 1'b0;
    bram_rddata1 = GARB; bram_rddata3 = GARB;

    vecs[0] = '{1'b1, 16'h4000, 32'h12345678, 4'hF, 0, 16'h4000, 4'hF};
    vecs[1] = '{1'b1, 16'h0002, 32'hAABBCCDD, 4'h3, 0, 16'h0000, 4'h3};
    vecs[2] = '{1'b1, 16'h1233, 32'h00000000, 4'h0, 0, 16'h1230, 4'h0};
    vecs[3] = '{1'b0, 16'hBFF8, 32'hCAFEF00D, 4'h0, 5, 16'hBFF8, 4'h0};
    vecs[4] = '{1'b0, 16'h0007, 32'h01020304, 4'h0, 0, 16'h0004, 4'h0};
    vecs[5] = '{1'b1, 16'hFFFF, 32'h80000001, 4'h8, 0, 16'hFFFC, 4'h8};

    // Reset state.
    mid();
    chk("rst_handshake", {26'd0, bus1.s_awready, bus1.s_wready, bus1.s_arready,
                          bus1.s_bvalid, bus1.s_rvalid, bram_en1}, 32'd0);
    chk("rst_bram_addr_we", {12'd0, bram_addr1, bram_we1}, 32'd0);
    chk("rst_wrdata", bram_wrdata1, 32'd0);
    chk("rst_rdata", bus1.s_rdata, 32'd0);
    chk("rst_resp", {28'd0, bus1.s_bresp, bus1.s_rresp}, 32'd0);
    repeat (2) next();
    rst = 1'b0;
    repeat (2) next();

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      base = en_cnt;
      if (vecs[i].is_wr) do_write(vecs[i]);
      else do_read(vecs[i]);
      next();
      chk("vec_bram_cycles", en_cnt - base, 32'd1);
    end

    // AW without W waits; both readies rise together once W arrives.
    next();
    base = en_cnt;
    bus1.s_awaddr = 16'h0010; bus1.s_wdata = 32'h55AA55AA; bus1.s_wstrb = 4'hF;
    bus1.s_awvalid = 1'b1; bus1.s_bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("aw_only_ready", {30'd0, bus1.s_awready, bus1.s_wready}, 32'd0);
      next();
    end
    bus1.s_wvalid = 1'b1;
    mid();
    chk("aw_w_ready", {30'd0, bus1.s_awready, bus1.s_wready}, 32'd3);
    next();
    bus1.s_awvalid = 1'b0; bus1.s_wvalid = 1'b0;
    repeat (6) next();
    bus1.s_bready = 1'b0;
    chk("aw_w_one_write", en_cnt - base, 32'd1);

    // Read/write contention, four rounds.
    bus1.s_bready = 1'b1; bus1.s_rready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      next();
      bus1.s_awaddr = 16'h0020; bus1.s_wdata = r; bus1.s_wstrb = 4'hF;
      bus1.s_araddr = 16'h0030;
      bus1.s_awvalid = 1'b1; bus1.s_wvalid = 1'b1; bus1.s_arvalid = 1'b1;
      mid();
      g = bus1.s_awready ? 1 : (bus1.s_arready ? 2 : 0);
`ifdef AXIL_BRAM_BRIDGE_RR_ARB_EN
      exp_g = (r % 2 == 0) ? 1 : 2;
`else
      exp_g = 1;
`endif
      chk("arb_grant", g, exp_g);
      chk("arb_w_eq_aw", {31'd0, bus1.s_wready}, {31'd0, bus1.s_awready});
      next();
      bus1.s_awvalid = 1'b0; bus1.s_wvalid = 1'b0; bus1.s_arvalid = 1'b0;
      repeat (7) next();
    end
    bus1.s_bready = 1'b0; bus1.s_rready = 1'b0;

    // READ_LATENCY=3: data sampled only in the slot three cycles after bram_en.
    next();
    bus3.s_araddr = 16'h8004; bus3.s_arvalid = 1'b1;
    mid();
    chk("rl3_arready", {31'd0, bus3.s_arready}, 32'd1);
    next();
    bus3.s_arvalid = 1'b0;
    mid();
    chk("rl3_bram_en", {31'd0, bram_en3}, 32'd1);
    chk("rl3_bram_addr", {16'd0, bram_addr3}, 32'h00008004);
    repeat (2) begin
      next();
      mid();
      chk("rl3_rvalid_early", {31'd0, bus3.s_rvalid}, 32'd0);
    end
    next();
    bram_rddata3 = 32'h0BADF00D;
    mid();
    chk("rl3_rvalid_early", {31'd0, bus3.s_rvalid}, 32'd0);
    next();
    bram_rddata3 = GARB;
    bus3.s_rready = 1'b1;
    mid();
    chk("rl3_rvalid", {31'd0, bus3.s_rvalid}, 32'd1);
    chk("rl3_rdata", bus3.s_rdata, 32'h0BADF00D);
    next();
    bus3.s_rready = 1'b0;
    mid();
    chk("rl3_rvalid_done", {31'd0, bus3.s_rvalid}, 32'd0);

    // Reset asserted while the read waits in RWAIT.
    next();
    bus1.s_araddr = 16'h0044; bus1.s_arvalid = 1'b1;
    next();
    bus1.s_arvalid = 1'b0;
    next();
    rst = 1'b1;
    #1;
    chk("midrst_handshake", {26'd0, bus1.s_awready, bus1.s_wready, bus1.s_arready,
                             bus1.s_bvalid, bus1.s_rvalid, bram_en1}, 32'd0);
    chk("midrst_bram_addr", {16'd0, bram_addr1}, 32'd0);
    chk("midrst_rdata", bus1.s_rdata, 32'd0);
    bus1.s_rready = 1'b1;
    bram_rddata1 = 32'h13579BDF;
    repeat (2) next();
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      mid();
      if (bus1.s_rvalid) rv_seen++;
      next();
    end
    chk("midrst_no_rvalid", rv_seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
